// File: rtl/axi_llc_miss_route.sv
// Routing stage between LLC tag lookup and the miss counters.
// Holds one descriptor and presents its ID/rw to the counters as a count-up request.
// The counters' to_miss/stall reply steers the descriptor to the hit or the miss pipeline.
// Dispatched hits and misses are counted in saturating performance counters.
//
// Ports:
//   clk_i, rst_i                       clock (rising edge), synchronous active-high reset
//   desc_valid_i/desc_ready_o          descriptor handshake from tag lookup
//   desc_id_i/rw_i/hit_i/payload_i     descriptor fields
//   cnt_up_id_o/rw_o/valid_o           count-up request to the miss counters (valid = miss fire)
//   to_miss_i, stall_i                 counter replies (same-ID miss outstanding, counter saturated)
//   hit_valid_o/hit_ready_i            hit pipeline handshake
//   miss_valid_o/miss_ready_i          miss pipeline handshake
//   out_id_o/out_rw_o/out_payload_o    held descriptor, shared by both pipelines
//   perf_hit_o, perf_miss_o            saturating dispatch counters
module axi_llc_miss_route #(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned PayloadWidth = 64,
    parameter int unsigned PerfCntWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [IdWidth-1:0]      desc_id_i,
    input  logic                    desc_rw_i,
    input  logic                    desc_hit_i,
    input  logic [PayloadWidth-1:0] desc_payload_i,
    output logic [IdWidth-1:0]      cnt_up_id_o,
    output logic                    cnt_up_rw_o,
    output logic                    cnt_up_valid_o,
    input  logic                    to_miss_i,
    input  logic                    stall_i,
    output logic                    hit_valid_o,
    input  logic                    hit_ready_i,
    output logic                    miss_valid_o,
    input  logic                    miss_ready_i,
    output logic [IdWidth-1:0]      out_id_o,
    output logic                    out_rw_o,
    output logic [PayloadWidth-1:0] out_payload_o,
    output logic [PerfCntWidth-1:0] perf_hit_o,
    output logic [PerfCntWidth-1:0] perf_miss_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PEND      = 2'd1,
        HIT_HOLD  = 2'd2,
        MISS_HOLD = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IdWidth-1:0]      id_q;
    logic                    rw_q;
    logic                    hit_q;
    logic [PayloadWidth-1:0] payload_q;
    logic [PerfCntWidth-1:0] perf_hit_q;
    logic [PerfCntWidth-1:0] perf_miss_q;

    logic route_miss;
    logic capture;
    logic hit_fire;
    logic miss_fire;

    // A hit is rerouted to the miss pipeline when an older same-ID (or write) miss is outstanding.
    assign route_miss = ~hit_q | to_miss_i;

    // Next-state, handshake and dispatch decode.
    always_comb begin
        state_d        = state_q;
        desc_ready_o   = 1'b0;
        hit_valid_o    = 1'b0;
        miss_valid_o   = 1'b0;
        cnt_up_valid_o = 1'b0;
        capture        = 1'b0;
        hit_fire       = 1'b0;
        miss_fire      = 1'b0;

        unique case (state_q)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (route_miss) begin
                    // A saturated counter blocks the miss until it drains.
                    if (!stall_i) begin
                        miss_valid_o = 1'b1;
                        if (miss_ready_i) miss_fire = 1'b1;
                        else              state_d   = MISS_HOLD;
                    end
                end else begin
                    hit_valid_o = 1'b1;
                    if (hit_ready_i) hit_fire = 1'b1;
                    else             state_d  = HIT_HOLD;
                end
            end
            HIT_HOLD: begin
                hit_valid_o = 1'b1;
                if (hit_ready_i) hit_fire = 1'b1;
            end
            MISS_HOLD: begin
                miss_valid_o = 1'b1;
                if (miss_ready_i) miss_fire = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Fire frees the slot; a waiting descriptor is taken in the same cycle.
        if (hit_fire || miss_fire) begin
            desc_ready_o = 1'b1;
            if (desc_valid_i) begin
                capture = 1'b1;
                state_d = PEND;
            end else begin
                state_d = IDLE;
            end
        end

        cnt_up_valid_o = miss_fire;

        // A reset cycle drops the held descriptor without dispatching it.
        if (rst_i) begin
            hit_valid_o    = 1'b0;
            miss_valid_o   = 1'b0;
            cnt_up_valid_o = 1'b0;
            hit_fire       = 1'b0;
            miss_fire      = 1'b0;
        end
    end

    // State and held descriptor.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            id_q      <= '0;
            rw_q      <= 1'b0;
            hit_q     <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                id_q      <= desc_id_i;
                rw_q      <= desc_rw_i;
                hit_q     <= desc_hit_i;
                payload_q <= desc_payload_i;
            end
        end
    end

    // Saturating dispatch counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            if (hit_fire && (perf_hit_q != '1))
                perf_hit_q <= perf_hit_q + PerfCntWidth'(1);
            if (miss_fire && (perf_miss_q != '1))
                perf_miss_q <= perf_miss_q + PerfCntWidth'(1);
        end
    end

    assign cnt_up_id_o   = (state_q != IDLE) ? id_q : '0;
    assign cnt_up_rw_o   = (state_q != IDLE) ? rw_q : 1'b0;
    assign out_id_o      = id_q;
    assign out_rw_o      = rw_q;
    assign out_payload_o = payload_q;
    assign perf_hit_o    = perf_hit_q;
    assign perf_miss_o   = perf_miss_q;

endmodule

// File: tb/tb_axi_llc_miss_route.sv
// Self-checking bench for axi_llc_miss_route: directed scenarios plus a
// randomized run against a transaction-level model. Perf counters are 4 bits
// wide so that saturation is reached quickly.
module tb_axi_llc_miss_route;

    localparam int unsigned IdW  = 4;
    localparam int unsigned PlW  = 64;
    localparam int unsigned PcW  = 4;
    localparam int          PMAX = 15;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           desc_valid_i;
    logic           desc_ready_o;
    logic [IdW-1:0] desc_id_i;
    logic           desc_rw_i;
    logic           desc_hit_i;
    logic [PlW-1:0] desc_payload_i;
    logic [IdW-1:0] cnt_up_id_o;
    logic           cnt_up_rw_o;
    logic           cnt_up_valid_o;
    logic           to_miss_i;
    logic           stall_i;
    logic           hit_valid_o;
    logic           hit_ready_i;
    logic           miss_valid_o;
    logic           miss_ready_i;
    logic [IdW-1:0] out_id_o;
    logic           out_rw_o;
    logic [PlW-1:0] out_payload_o;
    logic [PcW-1:0] perf_hit_o;
    logic [PcW-1:0] perf_miss_o;

    int n_cmp = 0;
    int n_err = 0;

    axi_llc_miss_route #(
        .IdWidth(IdW), .PayloadWidth(PlW), .PerfCntWidth(PcW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_id_i(desc_id_i), .desc_rw_i(desc_rw_i), .desc_hit_i(desc_hit_i),
        .desc_payload_i(desc_payload_i),
        .cnt_up_id_o(cnt_up_id_o), .cnt_up_rw_o(cnt_up_rw_o), .cnt_up_valid_o(cnt_up_valid_o),
        .to_miss_i(to_miss_i), .stall_i(stall_i),
        .hit_valid_o(hit_valid_o), .hit_ready_i(hit_ready_i),
        .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i),
        .out_id_o(out_id_o), .out_rw_o(out_rw_o), .out_payload_o(out_payload_o),
        .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic put_desc(input logic [IdW-1:0] id, input logic rw, input logic hit,
                            input logic [PlW-1:0] pl);
        desc_valid_i   = 1'b1;
        desc_id_i      = id;
        desc_rw_i      = rw;
        desc_hit_i     = hit;
        desc_payload_i = pl;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; desc_valid_i = 1'b0; desc_id_i = '0; desc_rw_i = 1'b0;
        desc_hit_i = 1'b0; desc_payload_i = '0; to_miss_i = 1'b0; stall_i = 1'b0;
        hit_ready_i = 1'b0; miss_ready_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        n_cmp++; if (hit_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_hit_valid got %b want 0", hit_valid_o); end
        n_cmp++; if (miss_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_miss_valid got %b want 0", miss_valid_o); end
        n_cmp++; if (cnt_up_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_cnt_up got %b want 0", cnt_up_valid_o); end
        n_cmp++; if (desc_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", desc_ready_o); end
        n_cmp++; if (perf_hit_o !== 4'd0 || perf_miss_o !== 4'd0) begin n_err++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_hit_o, perf_miss_o); end
        n_cmp++; if (out_payload_o !== 64'd0 || cnt_up_id_o !== 4'd0) begin n_err++; $display("FAIL reset_regs got %h/%0d want 0/0", out_payload_o, cnt_up_id_o); end
    endtask

    task automatic test_hit_path();
        logic [PlW-1:0] pl;
        pl = {$urandom, $urandom};
        put_desc(4'd3, 1'b0, 1'b1, pl);
        to_miss_i = 1'b0; hit_ready_i = 1'b1; miss_ready_i = 1'b1;
        tick();
        desc_valid_i = 1'b0;
        #1;
        n_cmp++; if (hit_valid_o !== 1'b1 || miss_valid_o !== 1'b0) begin n_err++; $display("FAIL hit_path_valid got h%b m%b want h1 m0", hit_valid_o, miss_valid_o); end
        n_cmp++; if (cnt_up_valid_o !== 1'b0) begin n_err++; $display("FAIL hit_path_cnt_up got %b want 0", cnt_up_valid_o); end
        n_cmp++; if (out_id_o !== 4'd3 || out_payload_o !== pl) begin n_err++; $display("FAIL hit_path_data got %0d/%h want 3/%h", out_id_o, out_payload_o, pl); end
        tick();
        n_cmp++; if (hit_valid_o !== 1'b0) begin n_err++; $display("FAIL hit_path_one_cycle got %b want 0", hit_valid_o); end
        n_cmp++; if (perf_hit_o !== 4'd1) begin n_err++; $display("FAIL hit_path_perf got %0d want 1", perf_hit_o); end
    endtask

    task automatic test_hit_forced_miss();
        put_desc(4'd2, 1'b0, 1'b1, {$urandom, $urandom});
        tick();
        desc_valid_i = 1'b0; to_miss_i = 1'b1; miss_ready_i = 1'b1;
        #1;
        n_cmp++; if (miss_valid_o !== 1'b1 || hit_valid_o !== 1'b0) begin n_err++; $display("FAIL forced_miss_valid got h%b m%b want h0 m1", hit_valid_o, miss_valid_o); end
        n_cmp++; if (cnt_up_valid_o !== 1'b1 || cnt_up_id_o !== 4'd2) begin n_err++; $display("FAIL forced_miss_cnt_up got %b id %0d want 1 id 2", cnt_up_valid_o, cnt_up_id_o); end
        tick();
        to_miss_i = 1'b0;
        n_cmp++; if (perf_miss_o !== 4'd1 || miss_valid_o !== 1'b0) begin n_err++; $display("FAIL forced_miss_perf got %0d valid %b want 1 valid 0", perf_miss_o, miss_valid_o); end
    endtask

    task automatic test_stall();
        put_desc(4'd5, 1'b1, 1'b0, {$urandom, $urandom});
        tick();
        desc_valid_i = 1'b0; stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (hit_valid_o !== 1'b0 || miss_valid_o !== 1'b0 || cnt_up_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_quiet cyc %0d got h%b m%b c%b want 000", i, hit_valid_o, miss_valid_o, cnt_up_valid_o); end
            tick();
        end
        stall_i = 1'b0;
        #1;
        n_cmp++; if (miss_valid_o !== 1'b1 || cnt_up_valid_o !== 1'b1 || cnt_up_rw_o !== 1'b1) begin n_err++; $display("FAIL stall_release got m%b c%b rw%b want 111", miss_valid_o, cnt_up_valid_o, cnt_up_rw_o); end
        tick();
        n_cmp++; if (perf_miss_o !== 4'd2) begin n_err++; $display("FAIL stall_perf got %0d want 2", perf_miss_o); end
    endtask

    task automatic test_stall_flip();
        put_desc(4'd6, 1'b0, 1'b1, {$urandom, $urandom});
        tick();
        desc_valid_i = 1'b0; to_miss_i = 1'b1; stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (hit_valid_o !== 1'b0 || miss_valid_o !== 1'b0) begin n_err++; $display("FAIL flip_quiet cyc %0d got h%b m%b want 00", i, hit_valid_o, miss_valid_o); end
            tick();
        end
        to_miss_i = 1'b0;
        #1;
        n_cmp++; if (hit_valid_o !== 1'b1 || miss_valid_o !== 1'b0 || cnt_up_valid_o !== 1'b0) begin n_err++; $display("FAIL flip_route got h%b m%b c%b want 100", hit_valid_o, miss_valid_o, cnt_up_valid_o); end
        tick();
        stall_i = 1'b0;
        n_cmp++; if (perf_hit_o !== 4'd2) begin n_err++; $display("FAIL flip_perf got %0d want 2", perf_hit_o); end
    endtask

    task automatic test_backpressure();
        logic [PlW-1:0] pl;
        int pulses;
        pl = {$urandom, $urandom};
        pulses = 0;
        put_desc(4'd9, 1'b0, 1'b0, pl);
        tick();
        desc_valid_i = 1'b0; miss_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            to_miss_i = 1'($urandom);
            stall_i   = (i == 0) ? 1'b0 : 1'($urandom);
            #1;
            pulses += int'(cnt_up_valid_o);
            n_cmp++; if (miss_valid_o !== 1'b1 || out_payload_o !== pl) begin n_err++; $display("FAIL bp_hold cyc %0d got m%b %h want m1 %h", i, miss_valid_o, out_payload_o, pl); end
            tick();
        end
        miss_ready_i = 1'b1; stall_i = 1'($urandom); to_miss_i = 1'($urandom);
        #1;
        pulses += int'(cnt_up_valid_o);
        n_cmp++; if (miss_valid_o !== 1'b1 || cnt_up_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_fire got m%b c%b want 11", miss_valid_o, cnt_up_valid_o); end
        tick();
        stall_i = 1'b0; to_miss_i = 1'b0;
        #1;
        pulses += int'(cnt_up_valid_o);
        n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL bp_pulses got %0d want 1", pulses); end
        n_cmp++; if (perf_miss_o !== 4'd3) begin n_err++; $display("FAIL bp_perf got %0d want 3", perf_miss_o); end
    endtask

    task automatic test_back_to_back();
        hit_ready_i = 1'b1; miss_ready_i = 1'b1; to_miss_i = 1'b0; stall_i = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) put_desc(4'(i), 1'b0, 1'(i % 2), {$urandom, $urandom});
            else       desc_valid_i = 1'b0;
            #1;
            if (i > 0) begin
                n_cmp++;
                if (out_id_o !== 4'(i - 1) || hit_valid_o !== 1'((i - 1) % 2) || miss_valid_o !== 1'(((i - 1) % 2) == 0)) begin
                    n_err++; $display("FAIL b2b_dispatch %0d got id %0d h%b m%b", i - 1, out_id_o, hit_valid_o, miss_valid_o);
                end
            end
            if (i < 8) begin
                n_cmp++; if (desc_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready %0d got %b want 1", i, desc_ready_o); end
            end
            tick();
        end
        n_cmp++; if (perf_hit_o !== 4'd6 || perf_miss_o !== 4'd7) begin n_err++; $display("FAIL b2b_perf got %0d/%0d want 6/7", perf_hit_o, perf_miss_o); end
    endtask

    task automatic test_saturation();
        hit_ready_i = 1'b1; miss_ready_i = 1'b1; to_miss_i = 1'b0; stall_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            put_desc(4'(i), 1'b0, 1'b1, {$urandom, $urandom});
            tick();
        end
        desc_valid_i = 1'b0;
        tick();
        n_cmp++; if (perf_hit_o !== 4'd15) begin n_err++; $display("FAIL sat_hit got %0d want 15", perf_hit_o); end
        for (int i = 0; i < 12; i++) begin
            put_desc(4'(i), 1'b1, 1'b0, {$urandom, $urandom});
            tick();
        end
        desc_valid_i = 1'b0;
        tick();
        n_cmp++; if (perf_miss_o !== 4'd15 || perf_hit_o !== 4'd15) begin n_err++; $display("FAIL sat_miss got %0d/%0d want 15/15", perf_hit_o, perf_miss_o); end
    endtask

    task automatic test_reset_in_hold();
        put_desc(4'd7, 1'b0, 1'b0, {$urandom, $urandom});
        miss_ready_i = 1'b0;
        tick();
        desc_valid_i = 1'b0;
        #1;
        n_cmp++; if (miss_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_hold_pre got %b want 1", miss_valid_o); end
        tick();
        rst_i = 1'b1; miss_ready_i = 1'b1;
        #1;
        n_cmp++; if (cnt_up_valid_o !== 1'b0 || miss_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_hold_nofire got c%b m%b want 00", cnt_up_valid_o, miss_valid_o); end
        tick();
        n_cmp++; if (cnt_up_valid_o !== 1'b0 || miss_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_hold_nofire2 got c%b m%b want 00", cnt_up_valid_o, miss_valid_o); end
        tick();
        rst_i = 1'b0;
        #1;
        n_cmp++; if (perf_miss_o !== 4'd0 || perf_hit_o !== 4'd0 || desc_ready_o !== 1'b1 || miss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rst_hold_after got perf %0d/%0d rdy %b m%b", perf_hit_o, perf_miss_o, desc_ready_o, miss_valid_o);
        end
    endtask

    // Randomized run. The model keeps a single-slot descriptor plus the path it
    // was first offered on; an offered descriptor may not change path.
    task automatic test_random();
        logic           m_full;
        int             m_path;   // 0 not yet offered, 1 hit, 2 miss
        logic [IdW-1:0] m_id;
        logic           m_rw, m_hit;
        logic [PlW-1:0] m_pl;
        int             m_ph, m_pm;
        logic           e_hv, e_mv, e_rdy, fire;
        m_full = 1'b0; m_path = 0; m_id = '0; m_rw = 1'b0; m_hit = 1'b0; m_pl = '0;
        m_ph = 0; m_pm = 0;
        for (int c = 0; c < 3000; c++) begin
            desc_valid_i   = ($urandom_range(9) < 7);
            desc_id_i      = 4'($urandom);
            desc_rw_i      = 1'($urandom);
            desc_hit_i     = 1'($urandom);
            desc_payload_i = {$urandom, $urandom};
            to_miss_i      = ($urandom_range(9) < 3);
            stall_i        = ($urandom_range(9) < 2);
            hit_ready_i    = ($urandom_range(9) < 7);
            miss_ready_i   = ($urandom_range(9) < 7);
            #1;
            e_hv = 1'b0; e_mv = 1'b0;
            if (m_full) begin
                if (m_path == 1)                e_hv = 1'b1;
                else if (m_path == 2)           e_mv = 1'b1;
                else if (!m_hit || to_miss_i)   e_mv = !stall_i;
                else                            e_hv = 1'b1;
            end
            fire  = (e_hv && hit_ready_i) || (e_mv && miss_ready_i);
            e_rdy = !m_full || fire;
            n_cmp++;
            if (hit_valid_o !== e_hv || miss_valid_o !== e_mv || cnt_up_valid_o !== (e_mv && miss_ready_i) || desc_ready_o !== e_rdy) begin
                n_err++; $display("FAIL rnd_ctrl cyc %0d got h%b m%b c%b r%b want h%b m%b c%b r%b", c,
                    hit_valid_o, miss_valid_o, cnt_up_valid_o, desc_ready_o, e_hv, e_mv, e_mv && miss_ready_i, e_rdy);
            end
            n_cmp++;
            if (cnt_up_id_o !== (m_full ? m_id : 4'd0) || cnt_up_rw_o !== (m_full && m_rw) ||
                (m_full && (out_id_o !== m_id || out_rw_o !== m_rw || out_payload_o !== m_pl))) begin
                n_err++; $display("FAIL rnd_data cyc %0d got id %0d rw %b pl %h want id %0d rw %b pl %h", c,
                    out_id_o, out_rw_o, out_payload_o, m_id, m_rw, m_pl);
            end
            n_cmp++;
            if (int'(perf_hit_o) != m_ph || int'(perf_miss_o) != m_pm) begin
                n_err++; $display("FAIL rnd_perf cyc %0d got %0d/%0d want %0d/%0d", c, perf_hit_o, perf_miss_o, m_ph, m_pm);
            end
            if (fire) begin
                if (e_hv && m_ph < PMAX) m_ph++;
                if (e_mv && m_pm < PMAX) m_pm++;
                m_full = 1'b0;
                m_path = 0;
            end else if (m_full) begin
                m_path = e_hv ? 1 : (e_mv ? 2 : 0);
            end
            if (e_rdy && desc_valid_i) begin
                m_full = 1'b1; m_path = 0;
                m_id = desc_id_i; m_rw = desc_rw_i; m_hit = desc_hit_i; m_pl = desc_payload_i;
            end
            tick();
        end
        desc_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hit_path();
        test_hit_forced_miss();
        test_stall();
        test_stall_flip();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
